// File: rtl/fft_frame_ctrl_if.sv
// Bus bundle between the frame controller, its sample source and the 32-point FFT core.
// The slave modport is the controller; the master modport is the source/FFT side.
interface fft_frame_ctrl_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic                fft_reset;
  logic                fft_start;
  logic [31:0]         fft_r_in;
  logic [31:0]         fft_i_in;
  logic                fft_sot;
  logic                fft_done;
  logic [31:0]         fft_r_out;
  logic [31:0]         fft_i_out;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  fft_reset,
    input  fft_start,
    input  fft_r_in,
    input  fft_i_in,
    output fft_sot,
    output fft_done,
    output fft_r_out,
    output fft_i_out
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output fft_reset,
    output fft_start,
    output fft_r_in,
    output fft_i_in,
    input  fft_sot,
    input  fft_done,
    input  fft_r_out,
    input  fft_i_out
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 32-point FFT: loads a sample frame, captures the output bins and
// reports the dominant positive-frequency bin by |re|+|im| magnitude, then re-arms the core.
module fft_frame_ctrl #(
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned N_PTS        = 32,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned REARM_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  fft_frame_ctrl_if.slave bus,
  output logic [4:0]      peak_bin,
  output logic [32:0]     peak_mag,
  output logic            result_valid,
  output logic            timeout_err,
  output logic            busy
);

  localparam int unsigned CW      = $clog2(N_PTS);
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam int unsigned RW      = $clog2(REARM_CYCLES + 1);
  localparam int unsigned LastPos = N_PTS / 2 - 1;

  localparam logic [2:0] StRearm   = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StLoad    = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StReport  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] rearm_cnt_q, rearm_cnt_d;
  logic [CW-1:0] smp_cnt_q, smp_cnt_d;
  logic [CW-1:0] bin_cnt_q, bin_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [32:0]   run_max_q, run_max_d;
  logic [CW-1:0] run_bin_q, run_bin_d;

  logic          s_ready_q, s_ready_d;
  logic          fft_reset_q, fft_reset_d;
  logic          fft_start_q, fft_start_d;
  logic [31:0]   fft_r_in_q, fft_r_in_d;
  logic [4:0]    peak_bin_q, peak_bin_d;
  logic [32:0]   peak_mag_q, peak_mag_d;
  logic          result_valid_q, result_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic [31:0]   sample_ext;
  logic [32:0]   re_abs, im_abs, mag;
  logic [32:0]   cap_max;
  logic [CW-1:0] cap_bin;
  logic          cap_last;

  assign accept     = bus.s_valid & s_ready_q;
  assign sample_ext = {{(32 - SAMPLE_W){bus.s_data[SAMPLE_W-1]}}, bus.s_data};

  // Negate in 33 bits so that |-2^31| = 2^31 does not wrap.
  assign re_abs = bus.fft_r_out[31] ? (33'd0 - {1'b1, bus.fft_r_out}) : {1'b0, bus.fft_r_out};
  assign im_abs = bus.fft_i_out[31] ? (33'd0 - {1'b1, bus.fft_i_out}) : {1'b0, bus.fft_i_out};
  assign mag    = re_abs + im_abs;

  // Running maximum including the bin presented this cycle; bin 1 seeds it.
  always_comb begin
    cap_max = run_max_q;
    cap_bin = run_bin_q;
    if (bus.fft_sot) begin
      if (bin_cnt_q == CW'(1)) begin
        cap_max = mag;
        cap_bin = bin_cnt_q;
      end else if ((bin_cnt_q <= CW'(LastPos)) && (mag > run_max_q)) begin
        cap_max = mag;
        cap_bin = bin_cnt_q;
      end
    end
  end

  assign cap_last = (bus.fft_sot && (bin_cnt_q == CW'(N_PTS - 1))) || bus.fft_done;

  always_comb begin
    state_d        = state_q;
    rearm_cnt_d    = rearm_cnt_q;
    smp_cnt_d      = smp_cnt_q;
    bin_cnt_d      = bin_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    run_max_d      = run_max_q;
    run_bin_d      = run_bin_q;
    s_ready_d      = 1'b0;
    fft_reset_d    = 1'b0;
    fft_start_d    = 1'b0;
    fft_r_in_d     = fft_r_in_q;
    peak_bin_d     = peak_bin_q;
    peak_mag_d     = peak_mag_q;
    result_valid_d = 1'b0;
    timeout_err_d  = 1'b0;

    unique case (state_q)
      StRearm: begin
        if (rearm_cnt_q == RW'(REARM_CYCLES - 1)) begin
          rearm_cnt_d = '0;
          state_d     = StIdle;
        end else begin
          fft_reset_d = 1'b1;
          rearm_cnt_d = rearm_cnt_q + RW'(1);
        end
      end

      StIdle: begin
        if (enable) begin
          s_ready_d = 1'b1;
          smp_cnt_d = '0;
          state_d   = StLoad;
        end
      end

      StLoad: begin
        s_ready_d = 1'b1;
        if (accept) begin
          fft_start_d = 1'b1;
          fft_r_in_d  = sample_ext;
          if (smp_cnt_q == CW'(N_PTS - 1)) begin
            s_ready_d = 1'b0;
            smp_cnt_d = '0;
            tmo_cnt_d = '0;
            state_d   = StWait;
          end else begin
            smp_cnt_d = smp_cnt_q + CW'(1);
          end
        end
      end

      StWait: begin
        if (bus.fft_sot) begin
          // This cycle carries bin 0 (DC), which never competes.
          bin_cnt_d = CW'(1);
          run_max_d = '0;
          run_bin_d = '0;
          if (bus.fft_done) begin
            peak_bin_d     = '0;
            peak_mag_d     = '0;
            result_valid_d = 1'b1;
            state_d        = StReport;
          end else begin
            state_d = StCapture;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          fft_reset_d   = 1'b1;
          rearm_cnt_d   = '0;
          state_d       = StRearm;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      StCapture: begin
        run_max_d = cap_max;
        run_bin_d = cap_bin;
        if (bus.fft_sot) begin
          bin_cnt_d = bin_cnt_q + CW'(1);
        end
        // Results are loaded here so result_valid lands one cycle after the last bin.
        if (cap_last) begin
          peak_bin_d     = 5'(cap_bin);
          peak_mag_d     = cap_max;
          result_valid_d = 1'b1;
          state_d        = StReport;
        end
      end

      StReport: begin
        fft_reset_d = 1'b1;
        rearm_cnt_d = '0;
        state_d     = StRearm;
      end

      default: begin
        fft_reset_d = 1'b1;
        rearm_cnt_d = '0;
        state_d     = StRearm;
      end
    endcase
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRearm;
      rearm_cnt_q    <= '0;
      smp_cnt_q      <= '0;
      bin_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      run_max_q      <= '0;
      run_bin_q      <= '0;
      s_ready_q      <= 1'b0;
      fft_reset_q    <= 1'b1;
      fft_start_q    <= 1'b0;
      fft_r_in_q     <= '0;
      peak_bin_q     <= '0;
      peak_mag_q     <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      rearm_cnt_q    <= rearm_cnt_d;
      smp_cnt_q      <= smp_cnt_d;
      bin_cnt_q      <= bin_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      run_max_q      <= run_max_d;
      run_bin_q      <= run_bin_d;
      s_ready_q      <= s_ready_d;
      fft_reset_q    <= fft_reset_d;
      fft_start_q    <= fft_start_d;
      fft_r_in_q     <= fft_r_in_d;
      peak_bin_q     <= peak_bin_d;
      peak_mag_q     <= peak_mag_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.fft_reset = fft_reset_q;
  assign bus.fft_start = fft_start_q;
  assign bus.fft_r_in  = fft_r_in_q;
  assign bus.fft_i_in  = '0;
  assign peak_bin      = peak_bin_q;
  assign peak_mag      = peak_mag_q;
  assign result_valid  = result_valid_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: the bench plays both the sample source and the FFT core,
// with hand-computed peak results for each frame.
module tb_fft_frame_ctrl;
  localparam int TmoLeft = 1024 - 3;  // load_frame already spends 3 WAIT cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  peak_bin;
  logic [32:0] peak_mag;
  logic        result_valid;
  logic        timeout_err;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int starts, results, tmos;
  int hi, n;

  logic [31:0] re_tab [32];
  logic [31:0] im_tab [32];
  logic [15:0] cos_tab [8];

  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.SAMPLE_W(16)) bif ();

  fft_frame_ctrl #(
    .SAMPLE_W(16),
    .N_PTS(32),
    .TIMEOUT(1024),
    .REARM_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bif),
    .peak_bin(peak_bin),
    .peak_mag(peak_mag),
    .result_valid(result_valid),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bif.fft_start) starts++;
    if (result_valid) results++;
    if (timeout_err) tmos++;
  endtask

  task automatic clear_bins();
    for (int k = 0; k < 32; k++) begin
      re_tab[k] = '0;
      im_tab[k] = '0;
    end
  endtask

  // Stream one 32-sample cosine frame, then idle three WAIT cycles.
  task automatic load_frame(input bit toggle, input bit chk_sext);
    int  sent  = 0;
    int  guard = 0;
    int  bad   = 0;
    bit  acc;
    starts  = 0;
    results = 0;
    tmos    = 0;
    while (sent < 32 && guard < 400) begin
      bif.s_valid = toggle ? (guard % 2 == 0) : 1'b1;
      bif.s_data  = cos_tab[sent % 8];
      acc = bif.s_valid && bif.s_ready;
      cyc();
      if (bif.fft_start !== acc) bad++;
      if (acc) begin
        sent++;
        if (chk_sext && sent == 4) chk("sext_neg", bif.fft_r_in, 64'hFFFF_FD3D);
      end
      guard++;
    end
    bif.s_valid = 1'b0;
    chk("s_ready_drop", bif.s_ready, 0);
    for (int i = 0; i < 3; i++) cyc();
    chk("start_count", starts, 32);
    chk("start_on_accept", bad, 0);
    chk("i_in_zero", bif.fft_i_in, 0);
  endtask

  task automatic send_bins(input int gap_at, input int last, input bit with_done);
    for (int k = 0; k <= last; k++) begin
      if (k == gap_at) begin
        bif.fft_sot   = 1'b0;
        bif.fft_r_out = 32'd50000;
        bif.fft_i_out = 32'd50000;
        cyc();
      end
      bif.fft_sot   = 1'b1;
      bif.fft_r_out = re_tab[k];
      bif.fft_i_out = im_tab[k];
      bif.fft_done  = with_done && (k == last);
      cyc();
    end
    bif.fft_sot  = 1'b0;
    bif.fft_done = 1'b0;
  endtask

  task automatic rearm_len(output int len);
    len = bif.fft_reset ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (!bif.fft_reset) break;
      len++;
    end
  endtask

  task automatic finish_frame(input string tag, input logic [4:0] e_bin, input logic [32:0] e_mag);
    int len;
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_bin"}, peak_bin, e_bin);
    chk({tag, "_mag"}, peak_mag, e_mag);
    rearm_len(len);
    chk({tag, "_rearm_len"}, len, 4);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_one_pulse"}, results, 1);
  endtask

  initial begin
    cos_tab[0] = 16'd1000;  cos_tab[1] = 16'd707;   cos_tab[2] = 16'd0;     cos_tab[3] = -16'd707;
    cos_tab[4] = -16'd1000; cos_tab[5] = -16'd707;  cos_tab[6] = 16'd0;     cos_tab[7] = 16'd707;
    reset = 1'b1;  enable = 1'b0;
    bif.s_valid = 1'b0;  bif.s_data = '0;
    bif.fft_sot = 1'b0;  bif.fft_done = 1'b0;  bif.fft_r_out = '0;  bif.fft_i_out = '0;
    cyc();
    cyc();
    chk("rst_fft_reset", bif.fft_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_s_ready", bif.s_ready, 0);
    chk("rst_fft_start", bif.fft_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_r_in", bif.fft_r_in, 0);

    // Reset cycle counts as the first REARM cycle; enable low then parks in IDLE.
    reset = 1'b0;
    rearm_len(hi);
    chk("rearm_after_reset", hi, 4);
    for (int i = 0; i < 5; i++) cyc();
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_ready", bif.s_ready, 0);
    enable = 1'b1;

    // Frame A: cosine at bin 4, no gaps.
    clear_bins();
    re_tab[4] = 32'd16000;
    load_frame(1'b0, 1'b1);
    send_bins(-1, 31, 1'b1);
    finish_frame("frameA", 5'd4, 33'd16000);

    // Frame B: s_valid toggling.
    load_frame(1'b1, 1'b0);
    send_bins(-1, 31, 1'b1);
    finish_frame("frameB", 5'd4, 33'd16000);

    // Frame C: DC ignored, tie rejected, bins above 15 ignored, sot gap mid-capture.
    clear_bins();
    re_tab[0]  = 32'd99999;
    re_tab[3]  = -32'd700;   im_tab[3] = 32'd300;
    re_tab[9]  = 32'd500;    im_tab[9] = 32'd500;
    re_tab[16] = 32'd5000;
    im_tab[31] = -32'd70000;
    load_frame(1'b0, 1'b0);
    send_bins(5, 31, 1'b1);
    finish_frame("frameC", 5'd3, 33'd1000);

    // Frame D: equal magnitude at bins 6 and 12.
    clear_bins();
    re_tab[6]  = 32'd800;
    re_tab[7]  = -32'd799;
    im_tab[12] = -32'd800;
    load_frame(1'b0, 1'b0);
    send_bins(-1, 31, 1'b1);
    finish_frame("frameD", 5'd6, 33'd800);

    // Frame E: no output phase -> timeout.
    load_frame(1'b0, 1'b0);
    n = 0;
    while (!timeout_err && n < 1100) begin
      cyc();
      n++;
    end
    chk("tmo_cycle", n, TmoLeft);
    chk("tmo_fft_reset", bif.fft_reset, 1);
    rearm_len(hi);
    chk("tmo_rearm_len", hi, 4);
    chk("tmo_idle", busy, 0);
    chk("tmo_one_pulse", tmos, 1);
    chk("tmo_no_result", results, 0);
    chk("tmo_keep_bin", peak_bin, 6);
    chk("tmo_keep_mag", peak_mag, 800);

    // Frame F: full-scale negative bin and an early fft_done at bin 7.
    clear_bins();
    re_tab[2] = 32'h8000_0000;  im_tab[2] = 32'h8000_0000;
    re_tab[3] = 32'h7FFF_FFFF;  im_tab[3] = 32'h7FFF_FFFF;
    load_frame(1'b0, 1'b0);
    send_bins(-1, 7, 1'b1);
    finish_frame("frameF", 5'd2, 33'h1_0000_0000);

    // Frame G: reset while bin 10 is presented.
    clear_bins();
    re_tab[4] = 32'd16000;
    load_frame(1'b0, 1'b0);
    send_bins(-1, 9, 1'b0);
    bif.fft_sot   = 1'b1;
    bif.fft_r_out = re_tab[10];
    bif.fft_i_out = im_tab[10];
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bif.fft_sot = 1'b0;
    chk("midrst_fft_reset", bif.fft_reset, 1);
    chk("midrst_busy", busy, 1);
    chk("midrst_s_ready", bif.s_ready, 0);
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_peak_bin", peak_bin, 0);
    chk("midrst_peak_mag", peak_mag, 0);
    chk("midrst_r_in", bif.fft_r_in, 0);

    // Frame H: normal frame after the mid-capture reset.
    load_frame(1'b0, 1'b0);
    send_bins(-1, 31, 1'b1);
    finish_frame("frameH", 5'd4, 33'd16000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer for the 32-point fixed-point FFT core in the frequency-detection path.
- Accepts a valid/ready sample stream and loads 32 samples per frame into the FFT.
- Waits for the FFT output phase and captures its 32 bins.
- Finds the dominant positive-frequency bin, reports it, then re-arms the core for the next frame.

Parameters:
SAMPLE_W, 16, input sample width; sign-extended to 32 bits toward the FFT.
N_PTS, 32, FFT length; fixed at 32, kept as a parameter for counter sizing only.
TIMEOUT, 1024, maximum cycles in WAIT before the frame is abandoned.
REARM_CYCLES, 4, number of cycles fft_reset is held high between frames.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  when low, no new frame starts; a frame already in progress completes.
s_data  in  SAMPLE_W  signed time-domain sample.
s_valid  in  1  s_data is valid.
s_ready  out  1  controller accepts s_data this cycle.
fft_reset  out  1  drives the FFT core reset.
fft_start  out  1  drives the FFT core start; one sample is loaded per cycle while high.
fft_r_in  out  32  sign-extended s_data.
fft_i_in  out  32  always 0.
fft_sot  in  1  FFT output-phase flag.
fft_done  in  1  FFT end-of-output flag.
fft_r_out  in  32  FFT bin, real part (signed).
fft_i_out  in  32  FFT bin, imaginary part (signed).
peak_bin  out  5  index of the largest-magnitude bin in the range 1..15.
peak_mag  out  33  magnitude of that bin, computed as |re|+|im|.
result_valid  out  1  one-cycle pulse when peak_bin and peak_mag are updated.
timeout_err  out  1  one-cycle pulse when a frame is abandoned.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - state = REARM; fft_reset = 1.
  - s_ready, fft_start, result_valid, timeout_err = 0.
  - peak_bin = 0, peak_mag = 0; fft_r_in = fft_i_in = 0.
  - busy = 1 (REARM is not IDLE).
  - All counters = 0.
- All outputs are registered.
- Reset asserted in any state overrides everything on the next edge.
- States: REARM, IDLE, LOAD, WAIT, CAPTURE, REPORT.
- REARM:
  - fft_reset = 1 for exactly REARM_CYCLES cycles, then go to IDLE.
  - Entered after reset, after REPORT, and after a timeout.
- IDLE:
  - busy = 0.
  - If enable = 1, assert s_ready and go to LOAD on the next edge.
- LOAD:
  - s_ready = 1.
  - Each cycle with s_valid & s_ready:
    - fft_start = 1 on the following cycle;
    - fft_r_in = sign-extended s_data;
    - sample counter increments.
  - On cycles with no accepted sample, fft_start = 0 (core pauses).
  - s_ready drops on the cycle after the 32nd accept; the 32nd fft_start pulse is the last.
  - Then go to WAIT and clear the timeout counter.
  - enable deasserting mid-LOAD has no effect.
- WAIT:
  - fft_start = 0.
  - Go to CAPTURE on the first cycle fft_sot = 1; that same cycle's fft_r_out/fft_i_out is bin 0.
  - If the timeout counter reaches TIMEOUT: pulse timeout_err and go to REARM; peak outputs are unchanged.
- CAPTURE:
  - Each cycle with fft_sot = 1 is bin k; k increments from 0.
  - mag = |re| + |im|, 33-bit unsigned. Two's-complement abs with the 33-bit result; the most negative value is handled without overflow.
  - Only bins 1..15 are compared.
  - Strictly-greater comparison, so ties keep the lower bin.
  - Running max is initialised to bin 1's magnitude.
  - After bin 31, or if fft_done = 1 first, go to REPORT.
  - If fft_done arrives before bin 15, the running max so far is reported.
  - A cycle with fft_sot = 0 mid-capture does not advance k.
- REPORT:
  - One cycle: load peak_bin/peak_mag, pulse result_valid, then go to REARM.
- Latency: result_valid fires 1 cycle after the final captured bin.
- Simultaneous s_valid in REARM/WAIT/CAPTURE/REPORT: the sample is not accepted (s_ready = 0).

Test Plan:
- Reset then enable = 1; stream 32 samples of a cosine at bin 4, amplitude 1000, no valid gaps; model FFT returns bin 4 = (16000, 0) and all other bins 0 -> exactly 32 fft_start pulses; result_valid once; peak_bin = 4; peak_mag = 16000; fft_reset high for 4 cycles afterwards.
- Same frame with s_valid toggling 1-0-1-0 -> fft_start pulses only on accepted samples; total 32; result identical.
- Model returns bin 3 = (-700, 300) and bin 9 = (500, 500); bin 0 = (99999, 0) -> peak_bin = 3, peak_mag = 1000 (DC ignored, ties/lower magnitudes rejected).
- Equal magnitude 800 at bins 6 and 12 -> peak_bin = 6.
- fft_sot never asserts, TIMEOUT = 1024 -> timeout_err pulses on WAIT cycle 1024; no result_valid; peak outputs retain the previous frame's values; controller returns to IDLE after 4 REARM cycles.
- Assert reset during CAPTURE at bin 10 -> next cycle all outputs are at reset values and fft_reset = 1; the following frame completes normally.
